// File: rtl/alu_issue_ctrl_if.sv
// Handshake and ALU bus bundle for the ALU issue controller.
// The master side is the environment: requester, result consumer and the
// combinational ALU. The slave side is the issue controller.
interface alu_issue_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OPRN_WIDTH = 6
);
  // request side
  logic                  req_valid;
  logic                  req_ready;
  logic [31:0]           instr_in;
  logic [DATA_WIDTH-1:0] rs_data;
  logic [DATA_WIDTH-1:0] rt_data;
  // ALU side
  logic [DATA_WIDTH-1:0] alu_op1;
  logic [DATA_WIDTH-1:0] alu_op2;
  logic [OPRN_WIDTH-1:0] alu_oprn;
  logic [DATA_WIDTH-1:0] alu_out;
  logic                  alu_zero;
  // result side
  logic                  res_valid;
  logic                  res_ready;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  res_zero;
  logic                  res_err;

  modport master (
    output req_valid, instr_in, rs_data, rt_data, alu_out, alu_zero, res_ready,
    input  req_ready, alu_op1, alu_op2, alu_oprn, res_valid, res_data, res_zero, res_err
  );

  modport slave (
    input  req_valid, instr_in, rs_data, rt_data, alu_out, alu_zero, res_ready,
    output req_ready, alu_op1, alu_op2, alu_oprn, res_valid, res_data, res_zero, res_err
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one instruction, decodes it into ALU
// operation/operands, captures the combinational ALU result one cycle later
// and hands it to the consumer over a valid/ready handshake.
// Sequence per request: IDLE -> DECODE -> EXEC -> DONE -> IDLE
// (illegal instructions skip EXEC and report an error).
module alu_issue_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int OPRN_WIDTH = 6
) (
  input logic             clk,
  input logic             rst,
  alu_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0a;
  localparam logic [5:0] OPC_ANDI  = 6'h0c;
  localparam logic [5:0] OPC_ORI   = 6'h0d;
  localparam logic [5:0] OPC_MULI  = 6'h1d;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a;
  localparam logic [5:0] FN_MUL = 6'h2c;

  localparam logic [OPRN_WIDTH-1:0] OPRN_NONE = OPRN_WIDTH'(4'd0);
  localparam logic [OPRN_WIDTH-1:0] OPRN_ADD  = OPRN_WIDTH'(4'd1);
  localparam logic [OPRN_WIDTH-1:0] OPRN_SUB  = OPRN_WIDTH'(4'd2);
  localparam logic [OPRN_WIDTH-1:0] OPRN_MUL  = OPRN_WIDTH'(4'd3);
  localparam logic [OPRN_WIDTH-1:0] OPRN_SRL  = OPRN_WIDTH'(4'd4);
  localparam logic [OPRN_WIDTH-1:0] OPRN_SLL  = OPRN_WIDTH'(4'd5);
  localparam logic [OPRN_WIDTH-1:0] OPRN_AND  = OPRN_WIDTH'(4'd6);
  localparam logic [OPRN_WIDTH-1:0] OPRN_OR   = OPRN_WIDTH'(4'd7);
  localparam logic [OPRN_WIDTH-1:0] OPRN_NOR  = OPRN_WIDTH'(4'd8);
  localparam logic [OPRN_WIDTH-1:0] OPRN_SLT  = OPRN_WIDTH'(4'd9);

  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  state_t                state_r;
  state_t                state_next_s;

  // latched request: only the opcode and the low half-word are needed,
  // register indices were already resolved by the register file read
  logic [5:0]            opcode_r;
  logic [15:0]           low_r;
  logic [DATA_WIDTH-1:0] rs_r;
  logic [DATA_WIDTH-1:0] rt_r;

  logic [5:0]            funct_s;
  logic [DATA_WIDTH-1:0] shamt_zx_s;
  logic [DATA_WIDTH-1:0] imm_sx_s;
  logic [DATA_WIDTH-1:0] imm_zx_s;

  logic                  dec_legal_s;
  logic [OPRN_WIDTH-1:0] dec_oprn_s;
  logic [DATA_WIDTH-1:0] dec_op1_s;
  logic [DATA_WIDTH-1:0] dec_op2_s;

  logic                  accept_s;
  logic                  unused_fields_s;

  logic                  req_ready_r;
  logic                  res_valid_r;
  logic [DATA_WIDTH-1:0] alu_op1_r;
  logic [DATA_WIDTH-1:0] alu_op2_r;
  logic [OPRN_WIDTH-1:0] alu_oprn_r;
  logic [DATA_WIDTH-1:0] res_data_r;
  logic                  res_zero_r;
  logic                  res_err_r;

  assign unused_fields_s = ^bus.instr_in[25:16];

  assign funct_s    = low_r[5:0];
  assign shamt_zx_s = {{(DATA_WIDTH-5){1'b0}}, low_r[10:6]};
  assign imm_sx_s   = {{(DATA_WIDTH-16){low_r[15]}}, low_r};
  assign imm_zx_s   = {{(DATA_WIDTH-16){1'b0}}, low_r};

  assign accept_s = bus.req_valid && req_ready_r;

  // Instruction decode of the latched request into ALU operation and operands.
  always_comb begin
    dec_legal_s = 1'b0;
    dec_oprn_s  = OPRN_NONE;
    dec_op1_s   = DATA_ZERO;
    dec_op2_s   = DATA_ZERO;
    case (opcode_r)
      OPC_RTYPE: begin
        dec_legal_s = 1'b1;
        dec_op1_s   = rs_r;
        dec_op2_s   = rt_r;
        case (funct_s)
          FN_ADD: dec_oprn_s = OPRN_ADD;
          FN_SUB: dec_oprn_s = OPRN_SUB;
          FN_MUL: dec_oprn_s = OPRN_MUL;
          FN_AND: dec_oprn_s = OPRN_AND;
          FN_OR:  dec_oprn_s = OPRN_OR;
          FN_NOR: dec_oprn_s = OPRN_NOR;
          FN_SLT: dec_oprn_s = OPRN_SLT;
          FN_SRL: begin
            dec_oprn_s = OPRN_SRL;
            dec_op1_s  = rt_r;
            dec_op2_s  = shamt_zx_s;
          end
          FN_SLL: begin
            dec_oprn_s = OPRN_SLL;
            dec_op1_s  = rt_r;
            dec_op2_s  = shamt_zx_s;
          end
          default: begin
            dec_legal_s = 1'b0;
            dec_op1_s   = DATA_ZERO;
            dec_op2_s   = DATA_ZERO;
          end
        endcase
      end
      OPC_ADDI: begin
        dec_legal_s = 1'b1;
        dec_oprn_s  = OPRN_ADD;
        dec_op1_s   = rs_r;
        dec_op2_s   = imm_sx_s;
      end
      OPC_MULI: begin
        dec_legal_s = 1'b1;
        dec_oprn_s  = OPRN_MUL;
        dec_op1_s   = rs_r;
        dec_op2_s   = imm_sx_s;
      end
      OPC_SLTI: begin
        dec_legal_s = 1'b1;
        dec_oprn_s  = OPRN_SLT;
        dec_op1_s   = rs_r;
        dec_op2_s   = imm_sx_s;
      end
      OPC_ANDI: begin
        dec_legal_s = 1'b1;
        dec_oprn_s  = OPRN_AND;
        dec_op1_s   = rs_r;
        dec_op2_s   = imm_zx_s;
      end
      OPC_ORI: begin
        dec_legal_s = 1'b1;
        dec_oprn_s  = OPRN_OR;
        dec_op1_s   = rs_r;
        dec_op2_s   = imm_zx_s;
      end
      default: begin
        dec_legal_s = 1'b0;
      end
    endcase
  end

  // Next-state selection for the issue sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = ST_DECODE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_DECODE: begin
        if (dec_legal_s) begin
          state_next_s = ST_EXEC;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      ST_EXEC: state_next_s = ST_DONE;
      ST_DONE: begin
        if (bus.res_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Handshake flags registered from the next state so they track it exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready_r <= 1'b0;
      res_valid_r <= 1'b0;
    end else begin
      req_ready_r <= (state_next_s == ST_IDLE);
      res_valid_r <= (state_next_s == ST_DONE);
    end
  end

  // Request capture, ALU drive and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_r   <= 6'd0;
      low_r      <= 16'd0;
      rs_r       <= DATA_ZERO;
      rt_r       <= DATA_ZERO;
      alu_op1_r  <= DATA_ZERO;
      alu_op2_r  <= DATA_ZERO;
      alu_oprn_r <= OPRN_NONE;
      res_data_r <= DATA_ZERO;
      res_zero_r <= 1'b0;
      res_err_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            opcode_r <= bus.instr_in[31:26];
            low_r    <= bus.instr_in[15:0];
            rs_r     <= bus.rs_data;
            rt_r     <= bus.rt_data;
          end
        end
        ST_DECODE: begin
          alu_oprn_r <= dec_oprn_s;
          alu_op1_r  <= dec_op1_s;
          alu_op2_r  <= dec_op2_s;
          if (!dec_legal_s) begin
            res_err_r  <= 1'b1;
            res_data_r <= DATA_ZERO;
            res_zero_r <= 1'b0;
          end
        end
        ST_EXEC: begin
          res_data_r <= bus.alu_out;
          res_zero_r <= bus.alu_zero;
          res_err_r  <= 1'b0;
        end
        default: begin
          res_err_r <= res_err_r;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.res_valid = res_valid_r;
  assign bus.alu_op1   = alu_op1_r;
  assign bus.alu_op2   = alu_op2_r;
  assign bus.alu_oprn  = alu_oprn_r;
  assign bus.res_data  = res_data_r;
  assign bus.res_zero  = res_zero_r;
  assign bus.res_err   = res_err_r;

endmodule
